// File: rtl/dm_debug_arbiter.sv
// Data-memory port arbiter: shares the single DM port between the CPU MEM stage and a debug reader.
// Optional auto-scan reader is enabled by defining DBG_DM_SCAN_EN.
module dm_debug_arbiter #(
  parameter int unsigned DBG_AW       = 10,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned SCAN_PERIOD  = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  output logic              cpu_stall,
  input  logic              dbg_en,
  input  logic              dbg_req,
  input  logic [DBG_AW-1:0] dbg_addr,
  input  logic              dbg_scan,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_valid,
  output logic [DBG_AW-1:0] dbg_cur_addr,
  output logic              dbg_busy,
  output logic [31:0]       dm_addr,
  output logic [31:0]       dm_wdata,
  output logic              dm_mem_read,
  output logic              dm_mem_write,
  input  logic [31:0]       dm_rdata
);

  localparam int unsigned WCW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DBG_RD = 2'd1, DBG_CAP = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [DBG_AW-1:0] req_addr_q, req_addr_d;
  logic [DBG_AW-1:0] rd_addr_q, rd_addr_d;
  logic [DBG_AW-1:0] cur_addr_q, cur_addr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              valid_q, valid_d;

  logic              new_req;
  logic [DBG_AW-1:0] new_addr;
  logic              accept;
  logic              pend_eff;
  logic [DBG_AW-1:0] addr_eff;
  logic              cpu_access;

`ifdef DBG_DM_SCAN_EN
  localparam int unsigned PCW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

  logic              scan_prev_q;
  logic [PCW-1:0]    period_q, period_d;
  logic [DBG_AW-1:0] scan_addr_q, scan_addr_d;
  logic              scanning, scan_rise, scan_tick;

  // While scanning, the injector replaces the external request source entirely.
  always_comb begin
    scanning    = dbg_scan && dbg_en;
    scan_rise   = scanning && !scan_prev_q;
    scan_tick   = scanning && !scan_rise && (period_q == PCW'(SCAN_PERIOD - 1));
    new_req     = scanning ? (scan_rise || scan_tick) : dbg_req;
    new_addr    = (scanning && !scan_rise) ? scan_addr_q : dbg_addr;
    period_d    = '0;
    if (scanning && !scan_rise && !scan_tick) period_d = period_q + 1'b1;
    scan_addr_d = scan_rise ? dbg_addr : scan_addr_q;
    if (scanning && new_req && !pending_q) scan_addr_d = new_addr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_prev_q <= 1'b0;
      period_q    <= '0;
      scan_addr_q <= '0;
    end else begin
      scan_prev_q <= dbg_scan;
      period_q    <= period_d;
      scan_addr_q <= scan_addr_d;
    end
  end
`else
  localparam int unsigned UNUSED_SCAN_PERIOD = SCAN_PERIOD;
  logic unused_scan;

  assign unused_scan = dbg_scan;
  assign new_req     = dbg_req;
  assign new_addr    = dbg_addr;
`endif

  assign cpu_access = cpu_mem_read || cpu_mem_write;
  assign accept     = dbg_en && new_req && !pending_q;
  assign pend_eff   = pending_q || accept;
  assign addr_eff   = pending_q ? req_addr_q : new_addr;

  // A request arriving in IDLE is arbitrated in the same cycle, giving DBG_RD one cycle later.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    pending_d  = dbg_en && pend_eff;
    req_addr_d = addr_eff;
    wait_cnt_d = dbg_en ? wait_cnt_q : '0;
    rd_addr_d  = rd_addr_q;
    cur_addr_d = cur_addr_q;
    rdata_d    = rdata_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (dbg_en && pend_eff) begin
          if (!cpu_access || wait_cnt_q == WCW'(STARVE_LIMIT)) begin
            state_d    = DBG_RD;
            rd_addr_d  = addr_eff;
            pending_d  = 1'b0;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end
      DBG_RD:  state_d = DBG_CAP;
      DBG_CAP: begin
        state_d    = IDLE;
        rdata_d    = dm_rdata;
        cur_addr_d = rd_addr_q;
        valid_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      wait_cnt_q <= '0;
      req_addr_q <= '0;
      rd_addr_q  <= '0;
      cur_addr_q <= '0;
      rdata_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      wait_cnt_q <= wait_cnt_d;
      req_addr_q <= req_addr_d;
      rd_addr_q  <= rd_addr_d;
      cur_addr_q <= cur_addr_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    dm_addr      = cpu_addr;
    dm_wdata     = cpu_wdata;
    dm_mem_read  = cpu_mem_read;
    dm_mem_write = cpu_mem_write;
    if (state_q == DBG_RD) begin
      dm_addr      = {{(32 - DBG_AW){1'b0}}, rd_addr_q};
      dm_mem_read  = 1'b1;
      dm_mem_write = 1'b0;
    end
  end

  assign cpu_stall    = (state_q == DBG_RD) && cpu_access;
  assign dbg_busy     = pending_q || (state_q != IDLE);
  assign dbg_rdata    = rdata_q;
  assign dbg_valid    = valid_q;
  assign dbg_cur_addr = cur_addr_q;

endmodule

// File: tb/tb_dm_debug_arbiter.sv
// Randomized self-checking bench for dm_debug_arbiter (default build, scan feature undefined).
// A cycle-level reference model predicts port ownership, stalls and captured debug data.
module tb_dm_debug_arbiter;
  localparam int unsigned DBG_AW       = 10;
  localparam int unsigned STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_mem_read, cpu_mem_write, cpu_stall;
  logic        dbg_en, dbg_req, dbg_scan, dbg_valid, dbg_busy;
  logic [9:0]  dbg_addr, dbg_cur_addr;
  logic [31:0] dbg_rdata, dm_addr, dm_wdata, dm_rdata;
  logic        dm_mem_read, dm_mem_write;

  always #5 clk = ~clk;

  dm_debug_arbiter #(.DBG_AW(DBG_AW), .STARVE_LIMIT(STARVE_LIMIT), .SCAN_PERIOD(3)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write), .cpu_stall(cpu_stall),
    .dbg_en(dbg_en), .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_scan(dbg_scan),
    .dbg_rdata(dbg_rdata), .dbg_valid(dbg_valid), .dbg_cur_addr(dbg_cur_addr), .dbg_busy(dbg_busy),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_mem_read(dm_mem_read), .dm_mem_write(dm_mem_write),
    .dm_rdata(dm_rdata)
  );

  // Synchronous data memory with one-cycle read latency.
  logic [31:0] mem [0:1023];
  logic [31:0] mem_rdata_q;
  always @(posedge clk) begin
    if (dm_mem_write) mem[dm_addr[9:0]] <= dm_wdata;
    if (dm_mem_read)  mem_rdata_q <= mem[dm_addr[9:0]];
  end
  assign dm_rdata = mem_rdata_q;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
  endtask

  // Reference model: m_phase counts debug-read cycles left (2 = port owned, 1 = capture, 0 = none).
  bit          m_known = 0;
  int          m_phase = 0;
  bit          m_pend = 0;
  int          m_wait = 0;
  logic [9:0]  m_paddr = '0, m_rd_addr = '0, m_cur = '0;
  logic [31:0] m_rdata = '0, m_capdata = '0;
  bit          m_valid = 0;
  logic [31:0] shadow [0:1023];
  int          n_valid = 0;

  bit          hold = 0;
  logic        h_rd, h_wr;
  logic [31:0] h_addr, h_wdata;

  task automatic step(input bit r, input bit en, input bit req, input logic [9:0] a,
                      input bit rd, input bit wr, input logic [31:0] ca, input logic [31:0] wd);
    bit in_rd, acc, pend, cpu;
    int ph;
    logic [9:0] pa;
    if (hold) begin
      rd = h_rd; wr = h_wr; ca = h_addr; wd = h_wdata;
    end
    rst = r; dbg_en = en; dbg_req = req; dbg_addr = a; dbg_scan = 1'($urandom_range(0, 1));
    cpu_mem_read = rd; cpu_mem_write = wr; cpu_addr = ca; cpu_wdata = wd;
    @(negedge clk);
    in_rd = (m_phase == 2);
    cpu   = rd || wr;
    if (m_known) begin
      check("cpu_stall", 32'(cpu_stall), 32'(in_rd && cpu));
      check("dbg_busy", 32'(dbg_busy), 32'(m_pend || m_phase != 0));
      check("dbg_valid", 32'(dbg_valid), 32'(m_valid));
      check("dbg_rdata", dbg_rdata, m_rdata);
      check("dbg_cur_addr", 32'(dbg_cur_addr), 32'(m_cur));
      check("dm_wdata", dm_wdata, wd);
      check("dm_addr", dm_addr, in_rd ? {22'd0, m_rd_addr} : ca);
      check("dm_mem_read", 32'(dm_mem_read), 32'(in_rd || rd));
      check("dm_mem_write", 32'(dm_mem_write), 32'(!in_rd && wr));
      if (dbg_valid === 1'b1) n_valid++;
    end
    hold = in_rd && cpu;
    h_rd = rd; h_wr = wr; h_addr = ca; h_wdata = wd;
    if (in_rd) m_capdata = shadow[m_rd_addr];
    if (wr && !in_rd) shadow[ca[9:0]] = wd;
    ph = m_phase;
    m_valid = 0;
    acc  = en && req && !m_pend;
    pend = m_pend || acc;
    pa   = m_pend ? m_paddr : a;
    if (ph == 2) m_phase = 1;
    else if (ph == 1) begin
      m_phase = 0; m_valid = 1; m_rdata = m_capdata; m_cur = m_rd_addr;
    end else if (en && pend && (!cpu || m_wait == STARVE_LIMIT)) begin
      m_phase = 2; m_rd_addr = pa; pend = 0; m_wait = 0;
    end else if (en && pend) m_wait++;
    m_pend = en && pend;
    m_paddr = pa;
    if (!en) m_wait = 0;
    if (r) begin
      m_known = 1; m_phase = 0; m_pend = 0; m_wait = 0; m_valid = 0;
      m_rdata = '0; m_cur = '0; hold = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 10'd0, 0, 0, 32'd0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom; shadow[i] = mem[i];
    end
    mem[5] = 32'hDEADBEEF; shadow[5] = 32'hDEADBEEF;
    @(posedge clk); #1;
    step(1, 0, 0, 10'd0, 0, 0, 32'd0, 32'd0);
    step(1, 0, 0, 10'd0, 0, 0, 32'd0, 32'd0);

    // Idle CPU: plain three-cycle debug read of address 5.
    step(0, 1, 1, 10'h005, 0, 0, 32'd0, 32'd0);
    idle(4);
    check("deadbeef_read", dbg_rdata, 32'hDEADBEEF);

    // Continuous CPU loads force a starvation grant; a store lands on the forced cycle.
    step(0, 1, 1, 10'h00C, 1, 0, 32'h10, 32'd0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 10'd0, 1, 0, 32'(i), 32'd0);
    step(0, 1, 0, 10'd0, 0, 1, 32'h8, 32'h12345678);
    step(0, 1, 0, 10'd0, 1, 0, 32'h20, 32'd0);
    idle(3);
    step(0, 1, 1, 10'h008, 0, 0, 32'd0, 32'd0);
    idle(4);
    check("store_readback", dbg_rdata, 32'h12345678);

    // Back-to-back requests: one during DBG_RD is queued, one during DBG_CAP is dropped.
    n_valid = 0;
    step(0, 1, 1, 10'h005, 0, 0, 32'd0, 32'd0);
    step(0, 1, 1, 10'h007, 0, 0, 32'd0, 32'd0);
    step(0, 1, 1, 10'h009, 0, 0, 32'd0, 32'd0);
    idle(8);
    check("two_valid_pulses", 32'(n_valid), 32'd2);
    check("last_addr_7", 32'(dbg_cur_addr), 32'h7);

    // Reset during DBG_RD, then dbg_en dropped while a request waits.
    step(0, 1, 1, 10'h003, 0, 0, 32'd0, 32'd0);
    step(1, 1, 0, 10'd0, 0, 0, 32'd0, 32'd0);
    idle(3);
    step(0, 1, 1, 10'h004, 1, 0, 32'h0, 32'd0);
    step(0, 0, 0, 10'h004, 1, 0, 32'h0, 32'd0);
    idle(2);

    // Randomized traffic in windows of differing CPU load and debug enable.
    for (int w = 0; w < 60; w++) begin
      int mode = $urandom_range(0, 2);
      bit en = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < 40; c++) begin
        int pct = (mode == 0) ? 10 : (mode == 1) ? 100 : 60;
        bit acc_on = ($urandom_range(1, 100) <= pct);
        bit is_wr = acc_on && ($urandom_range(0, 3) == 0);
        logic [9:0] a = ($urandom_range(0, 15) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
        step($urandom_range(0, 199) == 0, en, $urandom_range(0, 3) == 0, a,
             acc_on && !is_wr, is_wr, 32'($urandom_range(0, 15)), $urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dm_debug_arbiter.md
Name: dm_debug_arbiter

Overview:
- Owns the single data-memory port and shares it between the CPU MEM stage and the board debug reader (switches/LEDs).
- Replaces the static debug mux with a sequenced arbiter:
  - debug reads are queued and granted when the CPU leaves the port idle, or forced after a starvation limit with a CPU stall;
  - read data is captured into a holding register for display.
- Sits between the EX/MEM pipeline register and the data memory, which is synchronous with 1-cycle read latency.

Parameters:
- DBG_AW, 10: debug word-address width.
- STARVE_LIMIT, 4: cycles a pending debug read waits on a busy CPU before forced grant. 0 means grant immediately.
- SCAN_PERIOD, 25000000: cycles between auto-scan reads. Only used with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_addr  in  32  CPU memory address (ALU result)
- cpu_wdata  in  32  CPU store data
- cpu_mem_read  in  1  CPU load request
- cpu_mem_write  in  1  CPU store request
- cpu_stall  out  1  hold pipeline; CPU access not performed this cycle
- dbg_en  in  1  debug mode enable (level)
- dbg_req  in  1  debug read request (single-cycle pulse)
- dbg_addr  in  DBG_AW  debug word address (switches)
- dbg_scan  in  1  auto-scan mode (optional feature)
- dbg_rdata  out  32  last captured debug read data
- dbg_valid  out  1  one-cycle pulse when dbg_rdata updates
- dbg_cur_addr  out  DBG_AW  address of the data in dbg_rdata
- dbg_busy  out  1  request pending or in flight
- dm_addr  out  32  memory address
- dm_wdata  out  32  memory write data
- dm_mem_read  out  1  memory read enable
- dm_mem_write  out  1  memory write enable
- dm_rdata  in  32  memory read data, valid the cycle after the read

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - FSM = IDLE, pending = 0, wait_cnt = 0;
  - dbg_rdata = 0, dbg_cur_addr = 0, dbg_valid = 0, dbg_busy = 0, cpu_stall = 0.
  - Reset mid-operation aborts any in-flight read; no dbg_valid is produced for it.
- Port mux (combinational):
  - In DBG_RD: dm_addr = {(32-DBG_AW)'d0, req_addr}, dm_mem_read = 1, dm_mem_write = 0, dm_wdata = cpu_wdata.
  - Otherwise: dm_* pass cpu_* through unchanged.
- cpu_stall = (state == DBG_RD) && (cpu_mem_read || cpu_mem_write). It is never asserted in any other state.
- Request acceptance:
  - dbg_req && dbg_en && !pending sets pending and samples req_addr <= dbg_addr.
  - While pending is set, further requests are dropped (single-entry queue).
  - Acceptance is allowed in any state.
- FSM transitions:
  - IDLE: if pending && (!cpu_mem_read && !cpu_mem_write || wait_cnt == STARVE_LIMIT), go to DBG_RD, clear wait_cnt and clear pending. Else if pending, increment wait_cnt.
  - DBG_RD, one cycle, port owned by debug: go to DBG_CAP.
  - DBG_CAP, port back to CPU: dbg_rdata <= dm_rdata, dbg_cur_addr <= req_addr, dbg_valid <= 1 on the next cycle; go to IDLE.
  - A request accepted during DBG_RD or DBG_CAP is evaluated in IDLE on the following cycle.
- Latency: with the CPU idle, dbg_req high in cycle 0 gives DBG_RD in cycle 1, DBG_CAP in cycle 2, and dbg_valid = 1 with data in cycle 3.
- Holding: dbg_rdata and dbg_cur_addr hold between captures.
- dbg_busy = pending || state != IDLE.
- dbg_en deasserted:
  - pending and wait_cnt are cleared;
  - an in-flight DBG_RD/DBG_CAP completes normally, including dbg_valid;
  - no new acceptance occurs.
- Width: dbg_addr is a word index, zero-extended onto dm_addr with no shift.

Optional Feature:
- Macro: DBG_DM_SCAN_EN.
- Defined:
  - On the rising edge of dbg_scan (with dbg_en), the scan address is loaded from dbg_addr and the first request is issued immediately.
  - A period counter then injects an internal request every SCAN_PERIOD cycles while dbg_scan && dbg_en.
  - The scan address increments after each injection and wraps from 2^DBG_AW-1 to 0.
  - An injection collides with a pending request only if the previous read is unfinished; the injection is then dropped and the address does not advance.
  - External dbg_req is ignored while scanning.
- Undefined: dbg_scan is ignored, and no counter or scan logic is synthesized.

Test Plan:
- CPU idle, dbg_en = 1, dbg_addr = 10'h005, mem[5] = 32'hDEADBEEF, dbg_req pulse in cycle 0 -> dm_mem_read and dm_addr = 32'h5 in cycle 1; dbg_valid in cycle 3 with dbg_rdata = DEADBEEF, dbg_cur_addr = 5; cpu_stall never 1.
- CPU continuous loads, STARVE_LIMIT = 4, dbg_req at cycle 0 -> DBG_RD in cycle 5 with cpu_stall = 1 for exactly that cycle; the CPU load repeats at cycle 6 with the correct data.
- CPU store (addr 8, data 32'h12345678) coincident with forced DBG_RD -> store suppressed in that cycle and performed in the next; a later debug read of addr 8 returns 12345678.
- Second dbg_req during DBG_RD (addr 7), third during DBG_CAP (addr 9) -> addr 7 read next; addr 9 dropped; exactly two dbg_valid pulses.
- rst asserted in DBG_RD -> next cycle IDLE, dbg_rdata = 0, no dbg_valid; dbg_en cleared with a pending request -> pending cleared, dbg_busy = 0.
- With DBG_DM_SCAN_EN, SCAN_PERIOD = 3, dbg_addr = 10'h3FE, dbg_scan rises -> reads of 3FE, 3FF, 000, 001 at 3-cycle spacing; dbg_cur_addr follows each dbg_valid.
